// File: rtl/mem_bus_responder.sv
// mem_bus_responder
// Memory-side responder on the shared cache bus. Accepts one read or write at
// a time, serves it from a 2^AW x DW memory after MEM_LAT cycles, signals
// completion with a one-cycle finish pulse and announces every accepted write
// on the snoop port so peer caches can invalidate the line.
module mem_bus_responder #(
   parameter int MEM_LAT = 4,   // access latency, legal range 1..15
   parameter int AW      = 8,
   parameter int DW      = 8
) (
   input  logic          CC_clk,
   input  logic          rst,
   input  logic          bus_access,
   input  logic          write_opn_to_bus,
   input  logic [AW-1:0] read_select_Mem,
   input  logic [AW-1:0] write_select_Mem,
   input  logic [DW-1:0] write_data_Mem,
   output logic [DW-1:0] out_data_Mem,
   output logic          finish,
   output logic          mem_busy,
   output logic          flag_snoop,
   output logic [AW-1:0] snoop_address
);

   localparam int DEPTH = 1 << AW;
   localparam int CW    = 4;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   // One-cycle strobes decoded from the FSM
   logic accept;     // request taken in IDLE on this edge
   logic complete;   // access latency expires on this edge (enter RESPOND)

   // Request captured at acceptance; bus inputs are ignored afterwards
   logic          op_write;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] op_data;

   logic [DW-1:0] mem [DEPTH];

   // State and latency counter registers
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update from the same pre-edge values and simulation matches hardware.
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, counter and strobe decode
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (bus_access) begin
               accept     = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            // Requester withdrawing wins over completion: nothing is written
            // and no finish is issued for an aborted access.
            if (!bus_access) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else if (cnt == '0) begin
               complete   = 1'b1;
               state_next = RESPOND;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RESPOND: begin
            state_next = RELEASE;
         end
         RELEASE: begin
            // Held request must drop before a new one can be accepted
            if (!bus_access) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Busy whenever a transaction is anywhere in flight
   assign mem_busy = (state != IDLE);

   // Capture operation, selected address and write data at acceptance
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         op_write <= 1'b0;
         op_addr  <= '0;
         op_data  <= '0;
      end else if (accept) begin
         op_write <= write_opn_to_bus;
         op_addr  <= write_opn_to_bus ? write_select_Mem : read_select_Mem;
         op_data  <= write_data_Mem;
      end
   end

   // Snoop broadcast: one-cycle pulse per accepted write, address held after
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         flag_snoop    <= 1'b0;
         snoop_address <= '0;
      end else begin
         flag_snoop <= accept && write_opn_to_bus;
         if (accept && write_opn_to_bus) begin
            snoop_address <= write_select_Mem;
         end
      end
   end

   // Completion pulse, registered so it is high for the cycle after RESPOND
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         finish <= 1'b0;
      end else begin
         finish <= (state == RESPOND);
      end
   end

   // Main memory: identity pattern on reset, written when a write completes
   // NOTE: this array is reset deliberately so that location i reads back i
   // after rst; a reset array maps to flops rather than a RAM macro.
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= DW'(i);
         end
      end else if (complete && op_write) begin
         mem[op_addr] <= op_data;
      end
   end

   // Read data: loaded when a read completes and held until the next one
   always_ff @(posedge CC_clk or negedge rst) begin
      if (!rst) begin
         out_data_Mem <= '0;
      end else if (complete && !op_write) begin
         out_data_Mem <= mem[op_addr];
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder. Two instances run side by side:
// index 0 with the default latency of 4, index 1 with the minimum latency of 1.
// A transaction-level model tracks each instance by the age of its current
// request and is compared against the outputs on every falling edge; directed
// sequences add literal expectations, then randomized traffic follows.
module tb_mem_bus_responder;

   logic clk;
   logic rst;

   logic       ba       [2];
   logic       wr       [2];
   logic [7:0] ra       [2];
   logic [7:0] wa       [2];
   logic [7:0] wd       [2];
   logic [7:0] out_data [2];
   logic       fin      [2];
   logic       busy     [2];
   logic       snoop    [2];
   logic [7:0] saddr    [2];

   int lat [2] = '{4, 1};

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   mem_bus_responder #(.MEM_LAT(4), .AW(8), .DW(8)) u_dut_lat4 (
      .CC_clk           (clk),
      .rst              (rst),
      .bus_access       (ba[0]),
      .write_opn_to_bus (wr[0]),
      .read_select_Mem  (ra[0]),
      .write_select_Mem (wa[0]),
      .write_data_Mem   (wd[0]),
      .out_data_Mem     (out_data[0]),
      .finish           (fin[0]),
      .mem_busy         (busy[0]),
      .flag_snoop       (snoop[0]),
      .snoop_address    (saddr[0])
   );

   mem_bus_responder #(.MEM_LAT(1), .AW(8), .DW(8)) u_dut_lat1 (
      .CC_clk           (clk),
      .rst              (rst),
      .bus_access       (ba[1]),
      .write_opn_to_bus (wr[1]),
      .read_select_Mem  (ra[1]),
      .write_select_Mem (wa[1]),
      .write_data_Mem   (wd[1]),
      .out_data_Mem     (out_data[1]),
      .finish           (fin[1]),
      .mem_busy         (busy[1]),
      .flag_snoop       (snoop[1]),
      .snoop_address    (saddr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each instance is idle or holds one request of a given age (edges since
   // acceptance). The access window covers ages 0..lat-1, the memory operation
   // happens as the age reaches lat, finish is high for the cycle after the age
   // reaches lat+1, and from then on the request ends when bus_access drops.
   logic [7:0] m_mem [2][256];
   bit         m_act [2];
   int         m_age [2];
   bit         m_wr  [2];
   logic [7:0] m_adr [2];
   logic [7:0] m_dat [2];
   logic [7:0] e_out [2];
   logic       e_fin [2];
   logic       e_snp [2];
   logic [7:0] e_sad [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i++) m_mem[k][i] = 8'(i);
         m_act[k] = 1'b0;
         m_age[k] = 0;
         e_out[k] = 8'h00;
         e_fin[k] = 1'b0;
         e_snp[k] = 1'b0;
         e_sad[k] = 8'h00;
      end
   endtask

   task automatic model_step(input int k);
      e_fin[k] = 1'b0;
      e_snp[k] = 1'b0;
      if (!m_act[k]) begin
         if (ba[k]) begin
            m_act[k] = 1'b1;
            m_age[k] = 0;
            m_wr[k]  = wr[k];
            m_adr[k] = wr[k] ? wa[k] : ra[k];
            m_dat[k] = wd[k];
            if (wr[k]) begin
               e_snp[k] = 1'b1;
               e_sad[k] = wa[k];
            end
         end
      end else if (m_age[k] < lat[k]) begin
         if (!ba[k]) begin
            m_act[k] = 1'b0;
         end else begin
            m_age[k]++;
            if (m_age[k] == lat[k]) begin
               if (m_wr[k]) m_mem[k][m_adr[k]] = m_dat[k];
               else         e_out[k] = m_mem[k][m_adr[k]];
            end
         end
      end else if (m_age[k] == lat[k]) begin
         m_age[k]++;
         e_fin[k] = 1'b1;
      end else if (!ba[k]) begin
         m_act[k] = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // Compare process: all outputs are defined (held) every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
               check($sformatf("model_cmp[%0d] {busy,fin,snoop,saddr,out}", k),
                     {13'd0, busy[k], fin[k], snoop[k], saddr[k], out_data[k]},
                     {13'd0, m_act[k], e_fin[k], e_snp[k], e_sad[k], e_out[k]});
            end
         end
      end
   end

   // ---------------- requester tasks ----------------
   // Non-request inputs are scrambled while a transaction is in flight
   task automatic scramble(input int k);
      wr[k] = 1'($urandom);
      ra[k] = 8'($urandom);
      wa[k] = 8'($urandom);
      wd[k] = 8'($urandom);
   endtask

   task automatic do_txn(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int hold, output int lat_seen, output logic [7:0] rdata,
                         output logic snp_seen, output logic [7:0] snp_addr);
      bit found;
      @(negedge clk);
      wr[k] = w;
      ra[k] = w ? 8'($urandom) : a;
      wa[k] = w ? a : 8'($urandom);
      wd[k] = d;
      ba[k] = 1'b1;
      @(posedge clk);
      #1;
      snp_seen = snoop[k];
      snp_addr = saddr[k];
      found    = 1'b0;
      lat_seen = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         scramble(k);
         @(posedge clk);
         #1;
         lat_seen++;
         if (fin[k]) found = 1'b1;
      end
      rdata = out_data[k];
      if (!found) check("finish_timeout", 32'd0, 32'd1);
      check("finish_latency", 32'(lat_seen), 32'(lat[k] + 1));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         scramble(k);
         @(posedge clk);
         #1;
         check("held_no_second_finish", 32'(fin[k]), 32'd0);
         check("held_busy", 32'(busy[k]), 32'd1);
      end
      @(negedge clk);
      ba[k] = 1'b0;
      scramble(k);
      @(posedge clk);
      #1;
      check("release_to_idle", 32'(busy[k]), 32'd0);
   endtask

   task automatic do_abort(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                           input int drop_after);
      @(negedge clk);
      wr[k] = w;
      ra[k] = a;
      wa[k] = a;
      wd[k] = d;
      ba[k] = 1'b1;
      @(posedge clk);
      for (int c = 1; c < drop_after; c++) begin
         @(negedge clk);
         scramble(k);
         @(posedge clk);
      end
      @(negedge clk);
      ba[k] = 1'b0;
      @(posedge clk);
      #1;
      check("abort_idle", 32'(busy[k]), 32'd0);
      check("abort_no_finish", 32'(fin[k]), 32'd0);
      for (int c = 0; c < lat[k] + 2; c++) begin
         @(posedge clk);
         #1;
         check("abort_no_late_finish", 32'(fin[k]), 32'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int         ls;
      logic [7:0] rd;
      logic       sn;
      logic [7:0] sa;

      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ba[k] = 1'b0; wr[k] = 1'b0; ra[k] = 8'h00; wa[k] = 8'h00; wd[k] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check("reset_outputs", {13'd0, busy[k], fin[k], snoop[k], saddr[k], out_data[k]}, 32'd0);
      end
      @(posedge clk);
      #3 rst = 1'b1;

      // Reset readback of the identity pattern
      do_txn(0, 1'b0, 8'h3C, 8'h00, 0, ls, rd, sn, sa);
      check("readback_latency", 32'(ls), 32'd5);
      check("readback_data", 32'(rd), 32'h3C);
      check("read_no_snoop", 32'(sn), 32'd0);

      // Write then read the same address
      do_txn(0, 1'b1, 8'h10, 8'hA5, 0, ls, rd, sn, sa);
      check("write_snoop_flag", 32'(sn), 32'd1);
      check("write_snoop_addr", 32'(sa), 32'h10);
      check("write_latency", 32'(ls), 32'd5);
      do_txn(0, 1'b0, 8'h10, 8'h00, 0, ls, rd, sn, sa);
      check("raw_data", 32'(rd), 32'hA5);

      // Aborted write leaves memory untouched
      do_abort(0, 1'b1, 8'h20, 8'hFF, 2);
      do_txn(0, 1'b0, 8'h20, 8'h00, 0, ls, rd, sn, sa);
      check("abort_mem_untouched", 32'(rd), 32'h20);

      // Request held past finish
      do_txn(0, 1'b0, 8'h44, 8'h00, 3, ls, rd, sn, sa);
      check("held_data", 32'(rd), 32'h44);

      // Reset in the middle of a write access
      @(negedge clk);
      wr[0] = 1'b1; wa[0] = 8'h05; wd[0] = 8'h77; ba[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset_outputs", {13'd0, busy[0], fin[0], snoop[0], saddr[0], out_data[0]}, 32'd0);
      @(negedge clk);
      ba[0] = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      do_txn(0, 1'b0, 8'h05, 8'h00, 0, ls, rd, sn, sa);
      check("midreset_no_write", 32'(rd), 32'h05);

      // Minimum latency, back-to-back reads
      do_txn(1, 1'b0, 8'h01, 8'h00, 0, ls, rd, sn, sa);
      check("minlat_latency_a", 32'(ls), 32'd2);
      check("minlat_data_a", 32'(rd), 32'h01);
      do_txn(1, 1'b0, 8'h02, 8'h00, 0, ls, rd, sn, sa);
      check("minlat_latency_b", 32'(ls), 32'd2);
      check("minlat_data_b", 32'(rd), 32'h02);

      // Randomized traffic on both instances
      for (int n = 0; n < 160; n++) begin
         int         k;
         bit         w;
         logic [7:0] a;
         logic [7:0] d;
         k = int'($urandom_range(0, 1));
         w = 1'($urandom);
         a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         d = 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            do_abort(k, w, a, d, int'($urandom_range(1, lat[k])));
         end else begin
            do_txn(k, w, a, d, int'($urandom_range(0, 3)), ls, rd, sn, sa);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
